// File: rtl/main_if.sv
// rtl/main_if.sv - sample/result bundle for the main function evaluator
interface main_if #(
  parameter int CNT_W = 8
);
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             en;
  logic             clr;
  logic             f;
  logic [3:0]       minterm;
  logic [2:0]       ones;
  logic             parity;
  logic             f_valid;
  logic [CNT_W-1:0] rise_cnt;

  modport master (
    output a, b, c, d, en, clr,
    input  f, minterm, ones, parity, f_valid, rise_cnt
  );

  modport slave (
    input  a, b, c, d, en, clr,
    output f, minterm, ones, parity, f_valid, rise_cnt
  );
endinterface

// File: rtl/main.sv
// rtl/main.sv - registered 4-input truth-table evaluator with rise counter
// Define MAIN_INPUT_SYNC_EN to pass a,b,c,d,en through two-flop synchronisers.
module main #(
  parameter logic [15:0] FUNC_TT = 16'hF888,
  parameter int          CNT_W   = 8
) (
  input logic   clk,
  input logic   rst_n,
  main_if.slave bus
);

  logic [4:0] smp;

`ifdef MAIN_INPUT_SYNC_EN
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.a, bus.b, bus.c, bus.d, bus.en};
      sync2_q <= sync1_q;
    end
  end

  assign smp = sync2_q;
`else
  assign smp = {bus.a, bus.b, bus.c, bus.d, bus.en};
`endif

  logic [3:0]       idx;
  logic             s_en;
  logic             f_new;
  logic [2:0]       ones_new;
  logic             rise;
  logic             f_q;
  logic [3:0]       minterm_q;
  logic [2:0]       ones_q;
  logic             parity_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  assign idx      = smp[4:1];
  assign s_en     = smp[0];
  assign f_new    = FUNC_TT[idx];
  assign ones_new = {2'b00, idx[3]} + {2'b00, idx[2]} + {2'b00, idx[1]} + {2'b00, idx[0]};
  // A rise compares the incoming value against the value still held in f_q.
  assign rise     = s_en & f_new & ~f_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q       <= 1'b0;
      minterm_q <= 4'd0;
      ones_q    <= 3'd0;
      parity_q  <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q <= s_en;
      if (s_en) begin
        f_q       <= f_new;
        minterm_q <= idx;
        ones_q    <= ones_new;
        parity_q  <= ^idx;
      end
      if (bus.clr) begin
        cnt_q <= '0;
      end else if (rise && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.f        = f_q;
  assign bus.minterm  = minterm_q;
  assign bus.ones     = ones_q;
  assign bus.parity   = parity_q;
  assign bus.f_valid  = valid_q;
  assign bus.rise_cnt = cnt_q;

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - self-checking bench for main (8-bit and 2-bit counter instances)
module tb_main;

  logic clk;
  logic rst_n;

  main_if #(.CNT_W(8)) if0 ();
  main_if #(.CNT_W(2)) if1 ();

  main #(.FUNC_TT(16'hF888), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  main #(.FUNC_TT(16'hF888), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       m_f;
  logic [3:0] m_min;
  int         m_ones;
  logic       m_par;
  logic       m_valid;
  int         m_cnt;
  int         m_cnt2;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_f = 0; m_min = 0; m_ones = 0; m_par = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model(input logic [3:0] m, input logic en, input logic clr);
    logic nf;
    logic rise;
    nf   = (m[3] & m[2]) | (m[1] & m[0]);
    rise = en && nf && !m_f;
    if (en) begin
      m_f    = nf;
      m_min  = m;
      m_ones = $countones(m);
      m_par  = ^m;
    end
    m_valid = en;
    if (clr) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (rise) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".f"}, 32'(if0.f), 32'(m_f));
    chk({tag, ".minterm"}, 32'(if0.minterm), 32'(m_min));
    chk({tag, ".ones"}, 32'(if0.ones), 32'(m_ones));
    chk({tag, ".parity"}, 32'(if0.parity), 32'(m_par));
    chk({tag, ".f_valid"}, 32'(if0.f_valid), 32'(m_valid));
    chk({tag, ".rise_cnt"}, 32'(if0.rise_cnt), 32'(m_cnt));
    chk({tag, ".rise_cnt2"}, 32'(if1.rise_cnt), 32'(m_cnt2));
  endtask

  task automatic drive(input logic [3:0] m, input logic en, input logic clr);
    {if0.a, if0.b, if0.c, if0.d} = m;
    {if1.a, if1.b, if1.c, if1.d} = m;
    if0.en = en;  if1.en = en;
    if0.clr = clr; if1.clr = clr;
  endtask

  task automatic step(input logic [3:0] m, input logic en, input logic clr, input string tag);
    @(negedge clk);
    drive(m, en, clr);
    @(posedge clk);
    #1;
    model(m, en, clr);
    check_all(tag);
  endtask

  initial begin
    logic [3:0] rm;
    logic       ren;
    logic       rclr;

    rst_n = 1'b1;
    drive(4'hF, 1'b1, 1'b0);
    model_reset();
    #1 rst_n = 1'b0;

    // reset held with all inputs high
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    @(negedge clk);
    drive(4'hF, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check_all("reset_release");

    // truth table sweep
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b1, 1'b0, "sweep");
      chk("sweep_f_const", 32'(if0.f),
          32'((i == 3) || (i == 7) || (i == 11) || (i >= 12)));
      chk("sweep_minterm_const", 32'(if0.minterm), 32'(i));
    end
    step(4'b1011, 1'b1, 1'b0, "p1011");
    chk("p1011_ones", 32'(if0.ones), 32'd3);
    chk("p1011_parity", 32'(if0.parity), 32'd1);

    // enable gating
    step(4'b1100, 1'b1, 1'b0, "gate_on");
    chk("gate_on_valid", 32'(if0.f_valid), 32'd1);
    repeat (3) begin
      step(4'b0000, 1'b0, 1'b0, "gate_off");
      chk("gate_hold_f", 32'(if0.f), 32'd1);
      chk("gate_hold_min", 32'(if0.minterm), 32'd12);
      chk("gate_valid_low", 32'(if0.f_valid), 32'd0);
    end

    // rise counting: f = 0,1,1,0,1 then clr coincident with a rise
    step(4'b0000, 1'b1, 1'b1, "rise_clr");
    step(4'b1100, 1'b1, 1'b0, "rise1");
    step(4'b1111, 1'b1, 1'b0, "rise2");
    step(4'b0001, 1'b1, 1'b0, "rise3");
    step(4'b0011, 1'b1, 1'b0, "rise4");
    chk("rise_cnt_two", 32'(if0.rise_cnt), 32'd2);
    step(4'b0000, 1'b1, 1'b0, "rise5");
    step(4'b1100, 1'b1, 1'b1, "clr_prio");
    chk("clr_prio_cnt", 32'(if0.rise_cnt), 32'd0);
    chk("clr_keeps_f", 32'(if0.f), 32'd1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rm   = 4'($urandom_range(0, 15));
      ren  = ($urandom_range(0, 3) != 0);
      rclr = ($urandom_range(0, 31) == 0);
      step(rm, ren, rclr, "rand");
    end

    // saturate both counters
    step(4'b0000, 1'b1, 1'b1, "sat_clr");
    for (int i = 0; i < 265; i++) begin
      step(4'b1100, 1'b1, 1'b0, "sat_hi");
      step(4'b0000, 1'b1, 1'b0, "sat_lo");
    end
    chk("sat_cnt8", 32'(if0.rise_cnt), 32'd255);
    chk("sat_cnt2", 32'(if1.rise_cnt), 32'd3);

    // asynchronous reset mid-stream with f=1, rise_cnt=5
    step(4'b0000, 1'b1, 1'b1, "ar_clr");
    for (int i = 0; i < 5; i++) begin
      step(4'b1100, 1'b1, 1'b0, "ar_hi");
      if (i < 4) step(4'b0000, 1'b1, 1'b0, "ar_lo");
    end
    chk("ar_pre_f", 32'(if0.f), 32'd1);
    chk("ar_pre_cnt", 32'(if0.rise_cnt), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_f_now", 32'(if0.f), 32'd0);
    chk("ar_cnt_now", 32'(if0.rise_cnt), 32'd0);
    check_all("ar_all");
    @(negedge clk);
    drive(4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(4'b0000, 1'b0, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main.md
Name: main

Overview:
- Registered 4-input Boolean function evaluator with input-pattern statistics.
- Samples one-bit inputs a, b, c, d and evaluates a parameterised 16-entry truth table on them.
- Also reports the minterm index, population count and parity of the sample, and counts rising edges of the function output.
- Serves as the combinational-logic core of the project, wrapped in clocked registers for deterministic timing.

Parameters:
- FUNC_TT, 16'hF888, truth table indexed by minterm {a,b,c,d}; default implements f = a·b + c·d.
- CNT_W, 8, width of the rising-edge counter.

Ports:
- clk  input  1  system clock, all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- a  input  1  function input, minterm bit 3 (MSB)
- b  input  1  function input, minterm bit 2
- c  input  1  function input, minterm bit 1
- d  input  1  function input, minterm bit 0 (LSB)
- en  input  1  sample enable
- clr  input  1  synchronous clear of rise_cnt
- f  output  1  registered function value FUNC_TT[{a,b,c,d}]
- minterm  output  4  registered index {a,b,c,d}
- ones  output  3  registered count of inputs at 1 (0..4)
- parity  output  1  registered XOR of a,b,c,d
- f_valid  output  1  high for one cycle after each accepted sample
- rise_cnt  output  CNT_W  number of accepted samples where f went 0→1

Behaviour:
- Reset: rst_n low asynchronously forces all outputs to 0, regardless of clk.
  - Affected: f, minterm, ones, parity, f_valid, rise_cnt.
  - Outputs hold 0 until the first accepted sample after rst_n rises.
- Sample accept: at a rising clk edge with en=1, the inputs are captured and all registered outputs update at that edge.
  - Latency: 1 cycle from input to output.
  - minterm <= {a,b,c,d}.
  - f <= FUNC_TT[minterm value].
  - ones <= a+b+c+d, zero-extended to 3 bits.
  - parity <= a^b^c^d.
  - f_valid <= 1.
- en=0: f, minterm, ones and parity hold their values; f_valid <= 0.
- Rise detection: on an accepted sample, a rise occurs when the new f is 1 and the currently registered f is 0.
  - After reset, the registered f is 0, so a first sample with f=1 counts as a rise.
  - rise_cnt increments by 1 per rise.
  - rise_cnt saturates at 2^CNT_W−1 and does not wrap.
- Clear: clr=1 at a clock edge sets rise_cnt <= 0.
  - clr has priority over a simultaneous rise; that rise is not counted.
  - clr does not affect f, minterm, ones, parity or f_valid.
- Reset mid-operation: asynchronous; an in-flight sample is discarded.
- Inputs are sampled as-is and treated as synchronous to clk (default build, see below).

Optional Feature:
- Macro: MAIN_INPUT_SYNC_EN.
- Defined:
  - a, b, c, d and en each pass through a two-flop synchroniser before the evaluation stage.
  - Total latency becomes 3 cycles from pin to outputs.
  - Synchroniser flops reset to 0 on rst_n.
  - clr is not synchronised.
- Not defined: no synchroniser flops; latency is 1 cycle as specified above.

Test Plan:
- Reset: hold rst_n=0 with a=b=c=d=1, en=1 → all outputs 0 throughout; release → outputs 0 until the first edge.
- Default truth table sweep: en=1, apply minterms 0..15 one per cycle. Required one cycle later:
  - f=1 exactly for minterms 3, 7, 11, 12, 13, 14, 15.
  - minterm echoes the input.
  - ones and parity correct, e.g. minterm 4'b1011 → ones=3, parity=1.
- Enable gating: sample a,b,c,d=1,1,0,0 with en=1 (f=1), then change to 0,0,0,0 with en=0 for 3 cycles → outputs hold f=1, minterm=12; f_valid=1 only in the cycle after the en=1 sample.
- Rise counting: sequence of f values 0,1,1,0,1 from accepted samples → rise_cnt=2; then clr=1 coincident with a further 0→1 → rise_cnt=0.
- Saturation: with CNT_W=2, generate 5 rises → rise_cnt sticks at 3.
- Asynchronous reset mid-stream: assert rst_n low between clock edges while f=1 and rise_cnt=5 → both are 0 immediately, without waiting for clk.
